// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam int          ILEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Clears the byte-offset bits so every fetch address is word-aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory and decoder.
// Optional macro FETCH_MISALIGN_EN adds the fetch_misalign flag.
//
// Handshakes:
//  imem: a request transfers on a cycle with imem_req && imem_gnt; imem_addr and
//        imem_req stay stable until granted unless a redirect withdraws the request.
//        Responses (imem_rvalid) come back in request order, at least one cycle after gnt.
//  dec:  a word transfers on a cycle with dec_valid && dec_ready; dec_instr/dec_pc
//        do not change while dec_valid && !dec_ready.
interface instr_fetch_ctrl_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [ILEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            redirect;
  logic [ILEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [ILEN-1:0] dec_instr;
  logic [ILEN-1:0] dec_pc;
`ifdef FETCH_MISALIGN_EN
  logic            fetch_misalign;
`endif

  // Fetch controller side.
  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect, redirect_pc,
    output dec_valid, dec_instr, dec_pc,
    input  dec_ready
`ifdef FETCH_MISALIGN_EN
    , output fetch_misalign
`endif
  );

  // Memory / execute / decode side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect, redirect_pc,
    input  dec_valid, dec_instr, dec_pc,
    output dec_ready
`ifdef FETCH_MISALIGN_EN
    , input fetch_misalign
`endif
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush and a registered head.
// The head register holds its last value when the FIFO drains empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int             DEPTH      = 2,
  parameter int             W          = 64,
  parameter logic [W-1:0]   RESET_HEAD = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     head_valid_o,
  output logic [W-1:0]             head_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          do_pop, do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && !flush_i && ((count_q < CW'(DEPTH)) || do_pop);

  // Next pointers/count, and the entry that becomes the head next cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    count_d  = count_q - CW'(do_pop) + CW'(do_push);
    remain   = count_q - CW'(do_pop);
    head_d   = head_q;
    valid_d  = (count_d != '0);
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (do_push) begin
      head_d = push_data_i;
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      head_d   = head_q;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= RESET_HEAD;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = valid_q;
  assign head_data_o  = head_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// In-order instruction fetch controller: issues imem requests under a credit
// limit, buffers responses and presents them to decode; redirects flush the
// buffer and drop in-flight responses.
// Optional macro FETCH_MISALIGN_EN: misaligned redirect targets stop fetching
// and raise fetch_misalign until an aligned redirect arrives.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic                CLK,
  input  logic                RST_X,
  instr_fetch_ctrl_if.master  bus,
  output fetch_state_e        state_dbg_o
);

  localparam int CW  = $clog2(MAX_OUTST + 1) + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [FCW-1:0]  fifo_count;
  logic            head_valid;
  logic [63:0]     head_data;
  logic            credit_ok, gnt_fire, push, pop, redir_bad;
  logic [31:0]     redir_pc;

  assign redir_pc = align_pc(bus.redirect_pc);
`ifdef FETCH_MISALIGN_EN
  assign redir_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redir_bad = 1'b0;
`endif

  // Buffered words plus words still in flight must fit the FIFO.
  assign credit_ok = ((32'(fifo_count) + 32'(outst_q)) < 32'(FIFO_DEPTH)) &&
                     (32'(outst_q) < 32'(MAX_OUTST));
  assign bus.imem_req  = (state_q == RUN) && credit_ok && !bus.redirect;
  assign bus.imem_addr = fetch_pc_q;
  assign gnt_fire      = bus.imem_req && bus.imem_gnt;
  assign push          = bus.imem_rvalid && (state_q == RUN) && !bus.redirect;
  assign pop           = head_valid && bus.dec_ready;

  // Requests granted but not yet answered, including ones to be discarded.
  always_comb begin
    outst_d = outst_q + CW'(gnt_fire) - CW'(bus.imem_rvalid);
  end

  // Next state, fetch PC and discard count; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (gnt_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
    case (state_q)
      IDLE:  state_d = RUN;
      RUN:   state_d = RUN;
      DRAIN: begin
        if (bus.imem_rvalid) discard_d = discard_q - CW'(1);
        if (discard_d == '0) state_d = RUN;
      end
      FAULT: begin
        if (bus.imem_rvalid) discard_d = discard_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    if (bus.redirect) begin
      fetch_pc_d = redir_pc;
      discard_d  = outst_d;
      if (redir_bad)            state_d = FAULT;
      else if (outst_d == '0)   state_d = RUN;
      else                      state_d = DRAIN;
    end
  end

  // Controller registers.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .W          (64),
    .RESET_HEAD ({32'h0000_0000, NOP_INSTR})
  ) u_fifo (
    .clk_i        (CLK),
    .rst_ni       (RST_X),
    .push_i       (push),
    .push_data_i  ({fetch_pc_resp(), bus.imem_rdata}),
    .pop_i        (pop),
    .flush_i      (bus.redirect),
    .count_o      (fifo_count),
    .head_valid_o (head_valid),
    .head_data_o  (head_data)
  );

  // PC of the word currently returning: in-order responses lag the fetch PC
  // by the number of outstanding requests.
  function automatic logic [31:0] fetch_pc_resp();
    return fetch_pc_q - (32'(outst_q) << 2);
  endfunction

  assign bus.dec_valid = head_valid;
  assign bus.dec_instr = head_data[31:0];
  assign bus.dec_pc    = head_data[63:32];
`ifdef FETCH_MISALIGN_EN
  assign bus.fetch_misalign = (state_q == FAULT);
`endif
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: randomized memory/decoder/redirect stimulus,
// a queue-based reference model and per-cycle output comparison.
module tb_instr_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  localparam int MAXO  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if bus();
  fetch_state_e state_dbg;

  instr_fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTST(MAXO)) dut (
    .CLK(clk), .RST_X(rst_n), .bus(bus), .state_dbg_o(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // knobs
  bit rst_req = 1'b0;
  int k_gnt = 100, k_rdy = 100, k_red = 0, k_dmin = 1, k_dmax = 1;
  bit f_red = 1'b0;
  logic [31:0] f_pc = '0;
  int arm = 0;
  logic [31:0] arm_pc = '0;

  // memory model (stimulus side)
  logic [31:0] pend_a[$];
  int pend_t[$];
  int last_t = 0;

  // reference model
  fetch_state_e m_mode = IDLE;
  logic [31:0] m_pc = RESET_PC;
  logic [63:0] m_fifo[$];
  logic [31:0] m_infl[$];
  logic m_dv = 1'b0;
  logic [63:0] m_word = '0;
  bit m_known = 1'b0;

  // handshake log (DUT side)
  logic [31:0] hs_pc[$];
  logic [31:0] hs_instr[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_hs(input string name, input int idx, input logic [31:0] exp);
    if (idx < hs_pc.size()) chk(name, hs_pc[idx], exp);
    else begin
      n_cmp++; n_fail++;
      $display("FAIL %s: handshake #%0d never seen, expected pc %h", name, idx, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = IDLE; m_pc = RESET_PC; m_fifo.delete(); m_infl.delete();
    m_dv = 1'b0; m_word = {32'h0, NOP_INSTR}; m_known = 1'b1;
  endtask

  task automatic model_update(input bit r, input logic [31:0] rpc, input bit gf,
                              input bit v, input bit dr);
    logic [31:0] pc_ret;
    if (m_dv && dr) void'(m_fifo.pop_front());
    if (v) begin
      if (m_infl.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL resp_without_request: got response with %0d in flight expected none (cycle %0d)", m_infl.size(), cyc);
      end else begin
        pc_ret = m_infl.pop_front();
        if (m_mode == RUN && !r) m_fifo.push_back({pc_ret, mem_word(pc_ret)});
      end
    end
    if (gf) m_infl.push_back(m_pc);
    if (r) begin
      m_fifo.delete();
      m_pc = rpc & ~32'h3;
`ifdef FETCH_MISALIGN_EN
      if (rpc[1:0] != 2'b00) m_mode = FAULT; else
`endif
      m_mode = (m_infl.size() == 0) ? RUN : DRAIN;
      m_dv = 1'b0;
    end else begin
      if (gf) m_pc = m_pc + 32'd4;
      if (m_mode == IDLE) m_mode = RUN;
      else if (m_mode == DRAIN && m_infl.size() == 0) m_mode = RUN;
      m_dv = (m_fifo.size() > 0);
      if (m_dv) m_word = m_fifo[0];
    end
  endtask

  // ---------------- driver + compare, one cycle ----------------
  task automatic step();
    bit v, g, r, dr, exp_req;
    logic [31:0] rpc;
    int t;
    @(negedge clk);
    rst_n = rst_req;
    v  = rst_n && (pend_a.size() > 0) && (pend_t[0] <= cyc);
    g  = rst_n && ($urandom_range(99) < k_gnt);
    dr = ($urandom_range(99) < k_rdy);
    rpc = ($urandom_range(7) == 0) ? $urandom : ($urandom & ~32'h3);
    r  = ($urandom_range(999) < k_red);
    if (f_red) begin r = 1'b1; rpc = f_pc; f_red = 1'b0; end
    if (arm == 1 && m_infl.size() == 2) begin r = 1'b1; rpc = arm_pc; arm = 0; end
    if (arm == 2 && v && m_dv) begin r = 1'b1; dr = 1'b1; rpc = arm_pc; arm = 0; end
    if (!rst_n) r = 1'b0;
    bus.imem_gnt    = g;
    bus.imem_rvalid = v;
    if (v) bus.imem_rdata = mem_word(pend_a[0]);
    else   bus.imem_rdata = $urandom;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.dec_ready   = dr;
    #1;
    exp_req = 1'b0;
    if (m_known) begin
      exp_req = (m_mode == RUN) && ((m_fifo.size() + m_infl.size()) < DEPTH) &&
                (m_infl.size() < MAXO) && !r;
      chk("imem_req",  32'(bus.imem_req), 32'(exp_req));
      chk("imem_addr", bus.imem_addr, m_pc);
      chk("dec_valid", 32'(bus.dec_valid), 32'(m_dv));
      chk("dec_instr", bus.dec_instr, m_word[31:0]);
      chk("dec_pc",    bus.dec_pc, m_word[63:32]);
      chk("state",     32'(state_dbg), 32'(m_mode));
`ifdef FETCH_MISALIGN_EN
      chk("fetch_misalign", 32'(bus.fetch_misalign), 32'(m_mode == FAULT));
`endif
    end
    if (rst_n && bus.dec_valid && dr) begin
      hs_pc.push_back(bus.dec_pc);
      hs_instr.push_back(bus.dec_instr);
    end
    // memory side
    if (!rst_n) begin
      pend_a.delete(); pend_t.delete(); last_t = 0;
    end else begin
      if (v) begin void'(pend_a.pop_front()); void'(pend_t.pop_front()); end
      if (bus.imem_req && g) begin
        t = cyc + $urandom_range(k_dmax, k_dmin);
        if (t < last_t) t = last_t;
        last_t = t;
        pend_a.push_back(bus.imem_addr);
        pend_t.push_back(t);
      end
    end
    // reference model
    if (!rst_n) model_reset();
    else model_update(r, rpc, exp_req && g, v, dr);
    cyc++;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] stall_pc;
    rst_n = 1'b0;
    bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
    bus.redirect = 0; bus.redirect_pc = 0; bus.dec_ready = 0;

    // reset values
    rst_req = 1'b0;
    repeat (3) step();
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_dec_instr", bus.dec_instr, 32'h0000_0013);
    chk("rst_dec_pc", bus.dec_pc, 32'h0);

    // streaming with always-grant, 1-cycle response, always-ready
    rst_req = 1'b1;
    hs_pc.delete(); hs_instr.delete();
    repeat (20) step();
    chk_hs("stream_pc0", 0, 32'h0);
    chk_hs("stream_pc1", 1, 32'h4);
    chk_hs("stream_pc2", 2, 32'h8);
    if (hs_instr.size() > 0) chk("stream_instr0", hs_instr[0], mem_word(32'h0));

    // decoder stall: buffer fills, requests stop, head holds
    k_rdy = 0;
    repeat (10) step();
    stall_pc = m_word[63:32];
    chk("stall_imem_req", 32'(bus.imem_req), 32'd0);
    chk("stall_dec_valid", 32'(bus.dec_valid), 32'd1);
    chk("stall_buffered", 32'(m_fifo.size()), 32'(DEPTH));
    chk("stall_dec_instr", bus.dec_instr, mem_word(stall_pc));

    // redirect with two requests in flight
    k_rdy = 100; k_dmin = 3; k_dmax = 3;
    arm = 1; arm_pc = 32'h0000_0100; n = 0;
    while (arm != 0 && n < 50) begin step(); n++; end
    chk("drain_armed_fired", 32'(arm), 32'd0);
    hs_pc.delete(); hs_instr.delete();
    step();
    chk("drain_state", 32'(state_dbg), 32'(DRAIN));
    repeat (30) step();
    chk_hs("drain_first_pc", 0, 32'h0000_0100);
    if (hs_instr.size() > 0) chk("drain_first_instr", hs_instr[0], mem_word(32'h100));

    // redirect in the same cycle as a response and a decode pop
    k_dmin = 1; k_dmax = 2;
    arm = 2; arm_pc = 32'h0000_0200; n = 0;
    while (arm != 0 && n < 50) begin step(); n++; end
    chk("flush_armed_fired", 32'(arm), 32'd0);
    hs_pc.delete(); hs_instr.delete();
    step();
    chk("flush_dec_valid", 32'(bus.dec_valid), 32'd0);
    repeat (20) step();
    chk_hs("flush_first_pc", 0, 32'h0000_0200);

    // address wrap and request stability without grant
    k_gnt = 0;
    f_red = 1'b1; f_pc = 32'hFFFF_FFFC;
    step();
    hs_pc.delete(); hs_instr.delete();
    repeat (8) step();
    chk("hold_imem_req", 32'(bus.imem_req), 32'd1);
    chk("hold_imem_addr", bus.imem_addr, 32'hFFFF_FFFC);
    k_gnt = 100;
    step();
    step();
    chk("wrap_imem_addr", bus.imem_addr, 32'h0);
    repeat (12) step();
    chk_hs("wrap_pc0", 0, 32'hFFFF_FFFC);
    chk_hs("wrap_pc1", 1, 32'h0);

    // misaligned redirect target
    f_red = 1'b1; f_pc = 32'h0000_0102;
    step();
`ifdef FETCH_MISALIGN_EN
    step();
    chk("misalign_flag", 32'(bus.fetch_misalign), 32'd1);
    chk("misalign_req", 32'(bus.imem_req), 32'd0);
    repeat (5) step();
    chk("misalign_held", 32'(bus.fetch_misalign), 32'd1);
    f_red = 1'b1; f_pc = 32'h0000_0104;
    step();
    hs_pc.delete(); hs_instr.delete();
    repeat (15) step();
    chk("misalign_cleared", 32'(bus.fetch_misalign), 32'd0);
    chk_hs("misalign_recover_pc", 0, 32'h0000_0104);
`else
    hs_pc.delete(); hs_instr.delete();
    repeat (15) step();
    chk_hs("align_forced_pc", 0, 32'h0000_0100);
`endif

    // randomized traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        k_gnt = $urandom_range(100, 30);
        k_rdy = $urandom_range(100, 20);
        k_red = $urandom_range(60, 0);
        k_dmin = 1;
        k_dmax = $urandom_range(4, 1);
      end
      rst_req = !(i >= 1500 && i < 1502);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
